// File: rtl/bit_serial_subtractor.sv
// Multi-cycle unsigned subtractor: Diff = A - B - Bin, computed one bit per clock,
// LSB first, through a single 1-bit subtractor stage with a registered borrow.

module subtractor_1bit #(
  parameter int IMPL_TYPE = 0
) (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic sub,
  output logic bout
);
  generate
    if (IMPL_TYPE == 1) begin : g_maj
      // Borrow is the majority of (~a, b, bin)
      assign sub  = a ^ b ^ bin;
      assign bout = (~a & b) | (~a & bin) | (b & bin);
    end else begin : g_mux
      // When a != b the borrow is b itself; otherwise the incoming borrow propagates
      assign sub  = a ^ b ^ bin;
      assign bout = (a ^ b) ? b : bin;
    end
  endgenerate
endmodule

module bit_serial_subtractor #(
  parameter int WIDTH     = 8,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] op_a_reg, op_b_reg, result_reg, diff_reg;
  logic [CW-1:0]    cnt_reg;
  logic             borrow_reg, bout_reg, out_valid_reg;
  logic             sub_bit, sub_bout;
  logic [WIDTH-1:0] result_next;

  subtractor_1bit #(.IMPL_TYPE(IMPL_TYPE)) u_stage (
    .a   (op_a_reg[0]),
    .b   (op_b_reg[0]),
    .bin (borrow_reg),
    .sub (sub_bit),
    .bout(sub_bout)
  );

  // Each new difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
  assign result_next = {sub_bit, result_reg[WIDTH-1:1]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (cnt_reg == LAST_BIT) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      result_reg    <= '0;
      borrow_reg    <= 1'b0;
      cnt_reg       <= '0;
      diff_reg      <= '0;
      bout_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_a_reg   <= A;
            op_b_reg   <= B;
            borrow_reg <= Bin;
            cnt_reg    <= '0;
            result_reg <= '0;
          end
        end
        RUN: begin
          op_a_reg   <= op_a_reg >> 1;
          op_b_reg   <= op_b_reg >> 1;
          borrow_reg <= sub_bout;
          result_reg <= result_next;
          cnt_reg    <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_BIT) begin
            diff_reg      <= result_next;
            bout_reg      <= sub_bout;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign Diff      = diff_reg;
  assign Bout      = bout_reg;
endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Scoreboard bench: both stage implementations run on the same stimulus; each has its
// own expected-result queue drained by a monitor on the output handshake.

module tb_bit_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         bin_in = 1'b0;

  logic         in_ready0, out_valid0, bout0;
  logic [W-1:0] diff0;
  logic         in_ready1, out_valid1, bout1;
  logic [W-1:0] diff1;

  int checks = 0;
  int errors = 0;

  logic [W:0] q0[$];
  logic [W:0] q1[$];

  always #5 clk = ~clk;

  bit_serial_subtractor #(.WIDTH(W), .IMPL_TYPE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .A(a_in), .B(b_in), .Bin(bin_in), .out_valid(out_valid0),
    .out_ready(out_ready), .Diff(diff0), .Bout(bout0)
  );

  bit_serial_subtractor #(.WIDTH(W), .IMPL_TYPE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .A(a_in), .B(b_in), .Bin(bin_in), .out_valid(out_valid1),
    .out_ready(out_ready), .Diff(diff1), .Bout(bout1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitors: compare at negedge whenever a result handshake will complete
  always @(negedge clk) begin
    if (!rst && out_valid0 && out_ready) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL impl0_unexpected actual=0x%0h expected=none", {bout0, diff0});
      end else begin
        logic [W:0] e;
        e = q0.pop_front();
        if ({bout0, diff0} !== e) begin
          errors++;
          $display("FAIL impl0_result actual=0x%0h expected=0x%0h", {bout0, diff0}, e);
        end
        $display("impl0 result {Bout,Diff}=0x%0h", {bout0, diff0});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL impl1_unexpected actual=0x%0h expected=none", {bout1, diff1});
      end else begin
        logic [W:0] e;
        e = q1.pop_front();
        if ({bout1, diff1} !== e) begin
          errors++;
          $display("FAIL impl1_result actual=0x%0h expected=0x%0h", {bout1, diff1}, e);
        end
      end
    end
  end

  // Present operands until accepted; expected response is queued on acceptance
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input logic [W:0] exp);
    int n;
    a_in = a; b_in = b; bin_in = bin; in_valid = 1'b1;
    n = 0;
    while (!in_ready0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready0) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=in_ready0 expected=in_ready1");
      in_valid = 1'b0;
    end else begin
      q0.push_back(exp);
      q1.push_back(exp);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid0 && n < 100);
  endtask

  initial begin
    int n;
    logic [W-1:0] held_d;
    logic         held_b;

    #12 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_in_ready", in_ready0, 1);
    check("reset_out_valid", out_valid0, 0);
    check("reset_diff", diff0, 0);
    check("reset_bout", bout0, 0);

    // Basic op plus latency from accept edge to out_valid
    issue(8'h5A, 8'h3C, 1'b0, {1'b0, 8'h1E});
    wait_valid(n);
    check("latency", n, W + 1);
    check("impl1_latency_valid", out_valid1, 1);
    @(posedge clk); #1;

    issue(8'h00, 8'h01, 1'b0, {1'b1, 8'hFF});
    issue(8'h10, 8'h0F, 1'b1, {1'b0, 8'h00});
    issue(8'h80, 8'h7F, 1'b1, {1'b0, 8'h00});
    issue(8'h01, 8'h01, 1'b1, {1'b1, 8'hFF});
    issue(8'hFF, 8'h00, 1'b1, {1'b0, 8'hFE});

    // Backpressure: result must hold and new requests must be ignored
    wait_valid(n);
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(8'h33, 8'h11, 1'b0, {1'b0, 8'h22});
    wait_valid(n);
    check("bp_valid", out_valid0, 1);
    held_d = diff0;
    held_b = bout0;
    a_in = 8'hAA; b_in = 8'h55; bin_in = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_diff_stable", diff0, held_d);
      check("bp_bout_stable", bout0, held_b);
      check("bp_in_ready", in_ready0, 0);
      check("bp_out_valid", out_valid0, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp_drained_valid", out_valid0, 0);

    // Reset in RUN cycle 4 aborts the operation
    issue(8'h77, 8'h12, 1'b0, {1'b0, 8'h65});
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    #3;
    check("abort_out_valid", out_valid0, 0);
    check("abort_in_ready", in_ready0, 1);
    check("abort_diff", diff0, 0);
    check("abort_impl1_diff", diff1, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    issue(8'hFF, 8'hFF, 1'b0, {1'b0, 8'h00});

    // Random back-to-back against a WIDTH+1-bit golden
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] ra, rb;
      logic         rbin;
      logic [W:0]   g;
      ra = W'($urandom);
      rb = W'($urandom);
      rbin = 1'($urandom);
      g = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      issue(ra, rb, rbin, g);
    end

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
